// File: rtl/result_buffer_pool_pkg.sv
// Shared definitions for the result buffer pool: default geometry,
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package result_buffer_pool_pkg;

  localparam int DEF_NUM_CH = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_FMAP_W = 28;
  localparam int DEF_FMAP_H = 28;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POOL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/result_buffer_pool_if.sv
// Bus bundle for the result buffer pool: store port, pool control,
// read port and the sticky write-error flag.
interface result_buffer_pool_if
  import result_buffer_pool_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FMAP_W = DEF_FMAP_W,
  parameter int FMAP_H = DEF_FMAP_H
);
  localparam int DEPTH = FMAP_W * FMAP_H;
  localparam int AW    = clog2(DEPTH);
  localparam int CW    = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);

  // Handshake: a store is consumed on a rising edge where wr_valid and
  // wr_ready are both high; while wr_ready is low a held wr_valid is simply
  // not consumed. pool_start is sampled only when the block is idle, and
  // reads (rd_en) have no handshake: rd_data updates one edge later.
  logic                     wr_valid;
  logic                     wr_ready;
  logic [CW-1:0]            wr_ch;
  logic [AW-1:0]            wr_addr;
  logic                     wr_first;
  logic signed [DATA_W-1:0] wr_bias;
  logic signed [DATA_W-1:0] wr_value;
  logic                     pool_start;
  logic                     pool_busy;
  logic                     pool_done;
  logic                     rd_en;
  logic [CW-1:0]            rd_ch;
  logic [AW-1:0]            rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     wr_err;

  modport master (
    output wr_valid, wr_ch, wr_addr, wr_first, wr_bias, wr_value,
    output pool_start, rd_en, rd_ch, rd_addr,
    input  wr_ready, pool_busy, pool_done, rd_data, wr_err
  );

  modport slave (
    input  wr_valid, wr_ch, wr_addr, wr_first, wr_bias, wr_value,
    input  pool_start, rd_en, rd_ch, rd_addr,
    output wr_ready, pool_busy, pool_done, rd_data, wr_err
  );

endinterface

// File: rtl/result_buffer_pool_max4_relu.sv
// Combinational signed maximum of four elements followed by a ReLU clamp.
module max4_relu #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] y
);
  logic signed [W-1:0] m_ab;
  logic signed [W-1:0] m_cd;
  logic signed [W-1:0] m_all;

  assign m_ab  = (a > b) ? a : b;
  assign m_cd  = (c > d) ? c : d;
  assign m_all = (m_ab > m_cd) ? m_ab : m_cd;
  assign y     = m_all[W-1] ? '0 : m_all;

endmodule

// File: rtl/result_buffer_pool.sv
// Per-channel result buffers with bias/average accumulation on store and
// an in-place 2x2 max-pool + ReLU pass that compacts each bank's map.
module result_buffer_pool
  import result_buffer_pool_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FMAP_W = DEF_FMAP_W,
  parameter int FMAP_H = DEF_FMAP_H
) (
  input  logic                  clk,
  input  logic                  rst,
  result_buffer_pool_if.slave   bus,
  output state_t                dbg_state
);
  localparam int DEPTH  = FMAP_W * FMAP_H;
  localparam int AW     = clog2(DEPTH);
  localparam int CW     = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
  localparam int HALF_W = FMAP_W / 2;
  localparam int NWIN   = (FMAP_W / 2) * (FMAP_H / 2);

  if ((FMAP_W % 2) != 0 || (FMAP_H % 2) != 0 || NUM_CH < 1) begin : g_bad_params
    $error("result_buffer_pool: FMAP_W/FMAP_H must be even and NUM_CH >= 1");
  end

  state_t                   state, state_nx;
  logic [AW-1:0]            win_idx, win_r, win_c;
  logic [AW-1:0]            src0, src1, src2, src3;
  logic                     last_win, pool_we;
  logic                     wr_in_range, rd_in_range, store_fire;
  logic                     wr_err_q, pool_done_q;
  logic signed [DATA_W-1:0] rd_q, rd_mux;
  logic signed [DATA_W-1:0] bank_rd [NUM_CH];

  assign last_win    = (win_idx == AW'(NWIN - 1));
  assign pool_we     = (state == S_POOL);
  assign wr_in_range = (32'(bus.wr_ch) < 32'(NUM_CH)) && (32'(bus.wr_addr) < 32'(DEPTH));
  assign rd_in_range = (32'(bus.rd_ch) < 32'(NUM_CH)) && (32'(bus.rd_addr) < 32'(DEPTH));
  assign store_fire  = bus.wr_valid && bus.wr_ready && wr_in_range;

  // Top-left source of window (r, c) and its three neighbours.
  assign src0 = AW'(32'(win_r) * 32'(2 * FMAP_W) + 32'(win_c) * 32'd2);
  assign src1 = src0 + AW'(1);
  assign src2 = src0 + AW'(FMAP_W);
  assign src3 = src0 + AW'(FMAP_W + 1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state: pool_start only matters in IDLE, DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.pool_start) state_nx = S_POOL;
      S_POOL:  if (last_win) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Window counters walk raster order and wrap to (0,0) after the last window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_idx <= '0;
      win_r   <= '0;
      win_c   <= '0;
    end else if (state == S_POOL) begin
      win_idx <= last_win ? '0 : win_idx + 1'b1;
      if (win_c == AW'(HALF_W - 1)) begin
        win_c <= '0;
        win_r <= last_win ? '0 : win_r + 1'b1;
      end else begin
        win_c <= win_c + 1'b1;
      end
    end
  end

  // Completion pulse lands in the cycle after DONE, once busy has dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pool_done_q <= 1'b0;
    else     pool_done_q <= (state == S_DONE);
  end

  // Sticky flag for any accepted store aimed outside the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  wr_err_q <= 1'b0;
    else if (bus.wr_valid && bus.wr_ready && !wr_in_range)    wr_err_q <= 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_bank
    logic signed [DATA_W-1:0] mem [DEPTH];
    logic signed [DATA_W-1:0] cur, pool_res;
    logic signed [DATA_W:0]   acc_sum;
    logic                     bank_sel;

    // The sum of two DATA_W values needs one extra bit; dropping bit 0 is
    // the arithmetic shift, and the halved result always fits DATA_W.
    assign cur      = mem[bus.wr_addr];
    assign acc_sum  = {cur[DATA_W-1], cur} + {bus.wr_value[DATA_W-1], bus.wr_value};
    assign bank_sel = store_fire && (bus.wr_ch == CW'(g));

    max4_relu #(.W(DATA_W)) u_max4 (
      .a(mem[src0]), .b(mem[src1]), .c(mem[src2]), .d(mem[src3]), .y(pool_res)
    );

    // Pool writes own the bank in POOL; stores can only land in IDLE.
    // Compacted index never exceeds any source a later window still reads.
    always_ff @(posedge clk) begin
      if (pool_we)       mem[win_idx]     <= pool_res;
      else if (bank_sel) mem[bus.wr_addr] <= bus.wr_first ? bus.wr_bias : acc_sum[DATA_W:1];
    end

    assign bank_rd[g] = mem[bus.rd_addr];
  end

  // Select the addressed bank for the read port.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_ch == CW'(i)) rd_mux = bank_rd[i];
    end
  end

  // Registered read data; holds when rd_en is low, zero for out-of-range reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rd_q <= '0;
    else if (bus.rd_en) rd_q <= rd_in_range ? rd_mux : '0;
  end

  assign bus.pool_busy = (state != S_IDLE);
  assign bus.wr_ready  = (state == S_IDLE);
  assign bus.pool_done = pool_done_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.rd_data   = rd_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_result_buffer_pool.sv
// Bench for result_buffer_pool: randomized stores against an array model,
// read checking through an expected queue, pool timing and abort checks.
module tb_result_buffer_pool;
  import result_buffer_pool_pkg::*;

  localparam int NUM_CH = 6;
  localparam int DATA_W = 8;
  localparam int FMAP_W = 28;
  localparam int FMAP_H = 28;
  localparam int DEPTH  = FMAP_W * FMAP_H;
  localparam int NWIN   = (FMAP_W / 2) * (FMAP_H / 2);
  localparam int AW     = clog2(DEPTH);
  localparam int CW     = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);

  logic   clk;
  logic   rst;
  state_t dbg_state;

  result_buffer_pool_if #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FMAP_W(FMAP_W), .FMAP_H(FMAP_H)
  ) bus ();

  result_buffer_pool #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FMAP_W(FMAP_W), .FMAP_H(FMAP_H)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model and scoreboard ----------------
  int                ref_mem  [NUM_CH][DEPTH];
  int                snap_mem [NUM_CH][DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_exp;
  logic [DATA_W-1:0] got;
  bit                rd_fire;
  int                n_vec;
  int                n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rnd_s8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Mean of old and new value, rounded toward minus infinity.
  function automatic int floor_half(input int s);
    return (s >= 0) ? (s / 2) : -((-s + 1) / 2);
  endfunction

  // Pooling as specified: every window reads the pre-pool map.
  task automatic model_pool();
    int m, base;
    snap_mem = ref_mem;
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int r = 0; r < FMAP_H / 2; r++)
        for (int c = 0; c < FMAP_W / 2; c++) begin
          base = 2 * r * FMAP_W + 2 * c;
          m = snap_mem[ch][base];
          if (snap_mem[ch][base + 1] > m)          m = snap_mem[ch][base + 1];
          if (snap_mem[ch][base + FMAP_W] > m)     m = snap_mem[ch][base + FMAP_W];
          if (snap_mem[ch][base + FMAP_W + 1] > m) m = snap_mem[ch][base + FMAP_W + 1];
          ref_mem[ch][r * (FMAP_W / 2) + c] = (m < 0) ? 0 : m;
        end
  endtask

  // Read monitor: pops on each completed read, otherwise rd_data must hold.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_fire <= 1'b0;
    else     rd_fire <= bus.rd_en;
  end

  always @(negedge clk) begin
    got = bus.rd_data;
    if (rst) begin
      last_exp = '0;
    end else if (rd_fire) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got %0d, expected no read data", got);
      end else begin
        last_exp = exp_q.pop_front();
        check("rd_data", got, last_exp);
      end
    end else begin
      check("rd_hold", got, last_exp);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input int ch, input int addr, input bit first, input int bias, input int val);
    bus.wr_valid = 1'b1;
    bus.wr_ch    = CW'(ch);
    bus.wr_addr  = AW'(addr);
    bus.wr_first = first;
    bus.wr_bias  = DATA_W'(bias);
    bus.wr_value = DATA_W'(val);
    cycle();
    bus.wr_valid = 1'b0;
    if (ch < NUM_CH && addr < DEPTH) begin
      if (first) ref_mem[ch][addr] = bias;
      else       ref_mem[ch][addr] = floor_half(ref_mem[ch][addr] + val);
    end
  endtask

  task automatic rd_expect(input int ch, input int addr, input int exp);
    bus.rd_en   = 1'b1;
    bus.rd_ch   = CW'(ch);
    bus.rd_addr = AW'(addr);
    exp_q.push_back(DATA_W'(exp));
    cycle();
    bus.rd_en = 1'b0;
  endtask

  task automatic rd_model(input int ch, input int addr);
    int e;
    e = 0;
    if (ch < NUM_CH && addr < DEPTH) e = ref_mem[ch][addr];
    rd_expect(ch, addr, e);
  endtask

  task automatic read_all();
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int a = 0; a < DEPTH; a++) rd_model(ch, a);
  endtask

  // Start a pool (start edge T = first cycle) and check busy/ready/state/done
  // cycle by cycle; optionally hold junk stores, re-pulse start, or abort.
  task automatic pool_run(input bit hold_wr, input int abort_at);
    state_t exp_st;
    bus.pool_start = 1'b1;
    cycle();
    bus.pool_start = 1'b0;
    for (int j = 0; j <= NWIN + 6; j++) begin
      if (j == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_busy", bus.pool_busy, 0);
        check("abort_ready", bus.wr_ready, 1);
        check("abort_state", dbg_state, S_IDLE);
        check("abort_rd_data", bus.rd_data, 0);
        repeat (3) begin
          cycle();
          check("abort_no_done", bus.pool_done, 0);
        end
        rst = 1'b0;
        repeat (4) begin
          cycle();
          check("abort_no_done", bus.pool_done, 0);
          check("abort_idle", bus.pool_busy, 0);
          check("abort_wr_err", bus.wr_err, 0);
        end
        return;
      end
      exp_st = (j < NWIN) ? S_POOL : ((j == NWIN) ? S_DONE : S_IDLE);
      check("pool_busy", bus.pool_busy, (j <= NWIN) ? 1 : 0);
      check("wr_ready", bus.wr_ready, (j <= NWIN) ? 0 : 1);
      check("pool_done", bus.pool_done, (j == NWIN + 1) ? 1 : 0);
      check("pool_state", dbg_state, exp_st);
      bus.wr_valid   = hold_wr && (j <= NWIN);
      bus.wr_ch      = CW'($urandom_range(0, NUM_CH - 1));
      bus.wr_addr    = AW'($urandom_range(0, DEPTH - 1));
      bus.wr_first   = 1'($urandom_range(0, 1));
      bus.wr_bias    = DATA_W'(rnd_s8());
      bus.wr_value   = DATA_W'(rnd_s8());
      bus.pool_start = hold_wr && (j == 3);
      cycle();
    end
    bus.wr_valid   = 1'b0;
    bus.pool_start = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_ch = '0; bus.wr_addr = '0; bus.wr_first = 1'b0;
    bus.wr_bias = '0; bus.wr_value = '0; bus.pool_start = 1'b0;
    bus.rd_en = 1'b0; bus.rd_ch = '0; bus.rd_addr = '0;
    repeat (3) cycle();
    check("rst_ready", bus.wr_ready, 1);
    check("rst_busy", bus.pool_busy, 0);
    check("rst_done", bus.pool_done, 0);
    check("rst_wr_err", bus.wr_err, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst = 1'b0;
    cycle();

    // Store arithmetic on bank 3, address 10.
    do_store(3, 10, 1'b1, 5, 0);
    rd_expect(3, 10, 5);
    do_store(3, 10, 1'b0, 0, 9);
    rd_expect(3, 10, 7);
    do_store(3, 10, 1'b0, 0, -20);
    rd_expect(3, 10, 'hF9);

    // Fill: bank0 ramps up, bank1 all non-positive, the rest random.
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int a = 0; a < DEPTH; a++) begin
        if (ch == 0)      do_store(ch, a, 1'b1, a % 100, 0);
        else if (ch == 1) do_store(ch, a, 1'b1, -(a % 100), 0);
        else              do_store(ch, a, 1'b1, rnd_s8(), 0);
      end

    // Random accumulations with interleaved reads.
    for (int k = 0; k < 300; k++) begin
      do_store($urandom_range(2, NUM_CH - 1), $urandom_range(0, DEPTH - 1), 1'b0, 0, rnd_s8());
      if ((k % 3) == 0) rd_model($urandom_range(0, NUM_CH - 1), $urandom_range(0, DEPTH - 1));
    end

    // Out-of-range stores are dropped and latch wr_err.
    check("wr_err_clear", bus.wr_err, 0);
    do_store(0, DEPTH, 1'b1, 99, 0);
    check("wr_err_addr", bus.wr_err, 1);
    do_store(NUM_CH, 5, 1'b1, 99, 0);
    do_store(7, 1023, 1'b0, 0, 99);
    check("wr_err_sticky", bus.wr_err, 1);

    // Out-of-range reads return zero; then the whole buffer.
    rd_model(0, 3);
    rd_expect(NUM_CH, 0, 0);
    rd_expect(7, 5, 0);
    rd_expect(0, DEPTH, 0);
    rd_expect(2, 1023, 0);
    read_all();

    // Store coinciding with pool_start must be seen by the pool; stores held
    // during pooling and a second start are ignored.
    bus.wr_valid = 1'b1; bus.wr_ch = CW'(2); bus.wr_addr = AW'(0);
    bus.wr_first = 1'b0; bus.wr_bias = '0; bus.wr_value = DATA_W'(127);
    ref_mem[2][0] = floor_half(ref_mem[2][0] + 127);
    pool_run(1'b1, -1);
    model_pool();
    read_all();

    // Reset mid-pool aborts without pool_done; a fresh pool runs the full length.
    pool_run(1'b0, 50);
    pool_run(1'b0, -1);

    repeat (3) cycle();
    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/result_buffer_pool.md
RESULT_BUFFER_POOL -- requirements
Module: result_buffer_pool

Interface
REQ-001 Parameter NUM_CH, default 8, number of output-channel banks; SHALL be at least 1.
REQ-002 Parameter DATA_W, default 8, signed element width.
REQ-003 Parameters FMAP_W and FMAP_H, default 28 each, feature-map columns and rows; both SHALL be even, and elaboration SHALL fail otherwise.
REQ-004 Derived localparams: DEPTH = FMAP_W*FMAP_H; AW = clog2(DEPTH); CW = clog2(NUM_CH), minimum 1; NWIN = (FMAP_W/2)*(FMAP_H/2).
REQ-005 Ports (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  wr_valid  in  1  store request.
  wr_ready  out  1  store accepted; high only in IDLE.
  wr_ch  in  CW  target bank.
  wr_addr  in  AW  raster address, row*FMAP_W+col.
  wr_first  in  1  first write to this address; loads bias.
  wr_bias  in  DATA_W  signed bias.
  wr_value  in  DATA_W  signed partial result.
  pool_start  in  1  start 2x2 max-pool plus ReLU on all banks.
  pool_busy  out  1  pooling in progress.
  pool_done  out  1  one-cycle completion pulse.
  rd_en  in  1  read request.
  rd_ch  in  CW  read bank.
  rd_addr  in  AW  read address.
  rd_data  out  DATA_W  registered read data.
  wr_err  out  1  sticky out-of-range write flag.

Function
REQ-006 A store SHALL occur on an edge where wr_valid and wr_ready are both high.
REQ-007 If wr_first=1, the store SHALL set mem[wr_ch][wr_addr] to wr_bias.
REQ-008 If wr_first=0, the store SHALL set mem to (mem + wr_value) arithmetically shifted right by 1, computed in DATA_W+1 signed bits; no saturation is required, since the result always fits.
REQ-009 A store with wr_ch >= NUM_CH or wr_addr >= DEPTH SHALL be dropped and SHALL set wr_err, which stays set until reset.
REQ-010 The FSM SHALL have three states:
  - IDLE: goes to POOL on pool_start.
  - POOL: goes to DONE after NWIN cycles.
  - DONE: one cycle, then IDLE.
  pool_start outside IDLE SHALL be ignored.
REQ-011 POOL SHALL process one window per cycle, in raster window order (r outer, c inner), for all banks in parallel.
REQ-012 For window (r, c):
  - Sources SHALL be addresses 2r*FMAP_W+2c, +1, +FMAP_W and +FMAP_W+1.
  - Result SHALL be the signed maximum of the four sources, clamped to 0 if negative.
  - Result SHALL be written to compacted address r*(FMAP_W/2)+c.
REQ-013 The in-place compaction SHALL never overwrite a source that a later window still needs; raster order guarantees this.
REQ-014 Addresses at or above NWIN SHALL keep their pre-pool contents after pooling.
REQ-015 Timing: with pool_start sampled at edge T, windows are written at edges T+1 to T+NWIN, and pool_done is high during the cycle following edge T+NWIN+1.
REQ-016 pool_busy SHALL be high in POOL and DONE; wr_ready SHALL be the inverse of pool_busy.
REQ-017 If wr_valid and pool_start coincide in IDLE, the store SHALL complete at that edge and pooling SHALL see the stored value.
REQ-018 Reads SHALL have one-cycle latency: on an edge with rd_en high, rd_data takes mem[rd_ch][rd_addr].
REQ-019 A read with rd_ch or rd_addr out of range SHALL return 0.
REQ-020 When rd_en is low, rd_data SHALL hold its value.
REQ-021 Reads SHALL be permitted in every state; during POOL they return current, partly pooled contents.

Reset
REQ-022 On rst high, asynchronously:
  - the FSM SHALL go to IDLE;
  - pool_busy, pool_done, wr_err and rd_data SHALL be 0, and wr_ready SHALL be 1;
  - the window counters SHALL be 0.
REQ-023 Memory contents SHALL NOT be reset.
REQ-024 Reset asserted mid-POOL SHALL abort pooling with no pool_done pulse; after that, the memory is partially pooled and is not guaranteed.
REQ-025 The first pool_start after reset release SHALL start from window (0,0).

Structure
REQ-026 A shared package SHALL hold:
  - the FSM state encoding (IDLE, POOL, DONE);
  - the default values of NUM_CH, DATA_W, FMAP_W and FMAP_H;
  - a clog2 function.
REQ-027 Sub-module max4_relu SHALL be a parametrised-width combinational block (signed 4-input maximum, then clamp to 0), instantiated NUM_CH times.
REQ-028 Memories SHALL be one array per bank, generated with a generate loop.

Verification
REQ-029 Store arithmetic (bank 3, addr 10):
  - first write with bias=5 -> read returns 5;
  - then value=9 -> read returns 7;
  - then value=-20 -> read returns -7 (0xF9).
REQ-030 Pool mapping (NUM_CH=2, FMAP 4x4):
  - stimulus: bank0 filled with its address 0..15; bank1 filled with negated addresses; then pool_start.
  - bank0 addresses 0..3 SHALL read 5, 7, 13, 15.
  - bank1 addresses 0..3 SHALL read 0.
  - addresses 4..15 SHALL be unchanged.
  - pool_done SHALL pulse 5 cycles after the start edge.
REQ-031 Busy handling: wr_valid held throughout pooling -> wr_ready=0 and no memory change; a second pool_start during POOL -> ignored, giving a single pool_done.
REQ-032 Out-of-range write and read: store to wr_addr=DEPTH -> wr_err=1 and no memory change; read of rd_ch=NUM_CH -> rd_data=0.
REQ-033 Reset mid-pool (FMAP 28x28): assert rst at window 50 ->
  - pool_busy=0 immediately, with no pool_done pulse;
  - a new pool_start -> pool_done 197 cycles later.
